pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_wdog.sv | 39 +++
 rtl/pc_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared CPU definitions: fetch FSM states, NPC op codes, reset PC
package pc_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_JAL    = 2'd2,
      NPC_JALR   = 2'd3
   } npc_op_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_wdog.sv
// rtl/fetch_wdog.sv - counts cycles an instruction fetch stays outstanding; raises sticky timeout
module fetch_wdog #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic busy_i,
   input  logic done_i,
   output logic timeout_o
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;

   // Counting stops at the acknowledge edge, so a completed fetch never trips the flag.
   always_comb begin
      cnt_d = '0;
      if (busy_i && !done_i) begin
         cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
      end
      to_d = to_q | (cnt_d == MAX_C);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign timeout_o = to_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, instruction fetch FSM and IF/ID result register
import pc_fetch_ctrl_pkg::*;

module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        flush,
   output logic        misalign,
   output logic        timeout,
   output logic [31:0] fetch_cnt
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d, inst_q, inst_d, ipc_q, ipc_d, cnt_q, cnt_d;
   logic         valid_q, valid_d, flush_q, mis_q, mis_d;
   logic         deliver;

   assign deliver = (state_q == ST_WAIT) && imem_ack && !redirect;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (!redirect && !stall) state_d = ST_WAIT;
         ST_WAIT: begin
            if (redirect)      state_d = imem_ack ? ST_IDLE : ST_DROP;
            else if (imem_ack) state_d = stall ? ST_IDLE : ST_WAIT;
         end
         ST_DROP: if (imem_ack) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req = (state_q != ST_IDLE);
   end

   // Redirect wins over everything; a consumed result (stall=0) empties the slot.
   always_comb begin
      pc_d    = pc_q;
      valid_d = stall ? valid_q : 1'b0;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      cnt_d   = cnt_q;
      mis_d   = mis_q;
      if (redirect) begin
         pc_d    = align_pc(redirect_pc);
         valid_d = 1'b0;
         mis_d   = mis_q | (redirect_pc[1:0] != 2'b00);
      end else if (deliver) begin
         pc_d    = pc_q + 32'd4;
         valid_d = 1'b1;
         inst_d  = imem_rdata;
         ipc_d   = pc_q;
         cnt_d   = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         inst_q  <= '0;
         ipc_q   <= '0;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         cnt_q   <= cnt_d;
         flush_q <= redirect;
         mis_q   <= mis_d;
      end
   end

   fetch_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
      .clk       (clk),
      .rstn      (rstn),
      .busy_i    (state_q != ST_IDLE),
      .done_i    (imem_ack),
      .timeout_o (timeout)
   );

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign if_valid  = valid_q;
   assign if_inst   = inst_q;
   assign if_pc     = ipc_q;
   assign flush     = flush_q;
   assign misalign  = mis_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl against a transaction-level model
module tb_pc_fetch_ctrl;

   localparam int MAXW = 16;

   logic        clk = 1'b0, rstn = 1'b0, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
   logic [31:0] redirect_pc = '0, imem_rdata = '0;
   logic        imem_req, if_valid, flush, misalign, timeout;
   logic [31:0] imem_addr, pc, if_inst, if_pc, fetch_cnt;

   int n_cmp = 0, n_err = 0;

   // Model: is a request outstanding, is its answer to be thrown away, plus architectural outputs.
   logic        m_out, m_drop, m_valid, m_flush, m_mis, m_to;
   logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
   int          m_wait;

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
      .pc(pc), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .flush(flush),
      .misalign(misalign), .timeout(timeout), .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_drop = 0; m_valid = 0; m_flush = 0; m_mis = 0; m_to = 0;
      m_pc = 32'h0; m_inst = 0; m_ipc = 0; m_cnt = 0; m_wait = 0;
   endtask

   task automatic model_step();
      int w;
      w = (m_out && !imem_ack) ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
      m_wait = w;
      if (w == MAXW) m_to = 1;
      m_flush = redirect;
      if (redirect) begin
         if (redirect_pc[1:0] != 2'b00) m_mis = 1;
         m_pc = redirect_pc & 32'hFFFF_FFFC;
         m_valid = 0;
         if (m_out && imem_ack) m_out = 0;
         else if (m_out) m_drop = 1;
      end else if (m_out && imem_ack && m_drop) begin
         m_out = 0;
         if (!stall) m_valid = 0;
      end else if (m_out && imem_ack) begin
         m_valid = 1; m_inst = imem_rdata; m_ipc = m_pc;
         m_pc = m_pc + 4; m_cnt = m_cnt + 1;
         m_out = !stall;
      end else begin
         if (!stall) m_valid = 0;
         if (!m_out && !stall) m_out = 1;
      end
      if (!m_out) m_drop = 0;
   endtask

   task automatic check_all();
      chk("imem_req", 32'(imem_req), 32'(m_out));
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("if_valid", 32'(if_valid), 32'(m_valid));
      chk("if_inst", if_inst, m_inst);
      chk("if_pc", if_pc, m_ipc);
      chk("flush", 32'(flush), 32'(m_flush));
      chk("misalign", 32'(misalign), 32'(m_mis));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("fetch_cnt", fetch_cnt, m_cnt);
   endtask

   task automatic tick();
      if (imem_ack) chk("ack_slot_free", 32'(!(stall && if_valid)), 32'd1);
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic a);
      stall = s; redirect = r; redirect_pc = rp; imem_ack = a; imem_rdata = $urandom;
   endtask

   initial begin
      int          got;
      int          ackp;
      logic [31:0] addrs [5];

      model_reset();
      #3;
      check_all();
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Boot: five back-to-back fetches from the reset PC.
      got = 0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         drive(0, 0, 0, m_out);
         if (imem_ack) begin
            addrs[got] = imem_addr;
            got++;
         end
         tick();
      end
      chk("boot_fetches", got, 5);
      for (int i = 0; i < 5; i++) chk("boot_addr", addrs[i], 32'(4 * i));
      chk("boot_cnt", fetch_cnt, 32'd5);
      chk("boot_if_pc", if_pc, 32'd16);

      // Stall holds the IF/ID result.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0);
         tick();
         chk("stall_hold_valid", 32'(if_valid), 32'd1);
         chk("stall_hold_pc", if_pc, 32'd16);
      end
      drive(0, 0, 0, 1);
      tick();
      chk("after_stall_if_pc", if_pc, 32'd20);

      // Redirect in WAIT, stale word arrives two cycles later.
      drive(0, 1, 32'h100, 0); tick();
      chk("redir_flush", 32'(flush), 32'd1);
      drive(0, 0, 0, 0); tick();
      chk("redir_flush_once", 32'(flush), 32'd0);
      drive(0, 0, 0, 1); tick();
      chk("redir_discard", fetch_cnt, 32'd6);
      drive(0, 0, 0, 0); tick();
      chk("redir_target", imem_addr, 32'h100);

      // Redirect together with acknowledge.
      drive(0, 1, 32'h300, 1); tick();
      chk("redir_ack_valid", 32'(if_valid), 32'd0);
      chk("redir_ack_cnt", fetch_cnt, 32'd6);
      drive(0, 0, 0, 0); tick();
      chk("redir_ack_target", imem_addr, 32'h300);

      // Misaligned target.
      drive(0, 1, 32'h203, 0); tick();
      chk("mis_flag", 32'(misalign), 32'd1);
      chk("mis_pc", pc, 32'h200);
      drive(0, 0, 0, 1); tick();
      drive(0, 0, 0, 0); tick();
      chk("mis_sticky", 32'(misalign), 32'd1);

      // PC wraps past the top of the address space.
      drive(0, 1, 32'hFFFF_FFFC, 0); tick();
      drive(0, 0, 0, 1); tick();
      drive(0, 0, 0, 0); tick();
      drive(0, 0, 0, 1); tick();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

      // Withheld acknowledge trips the watchdog after MAX_WAIT cycles.
      for (int i = 0; i < MAXW - 1; i++) begin
         drive(0, 0, 0, 0); tick();
      end
      chk("timeout_early", 32'(timeout), 32'd0);
      drive(0, 0, 0, 0); tick();
      chk("timeout_set", 32'(timeout), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0); tick();
      end
      chk("timeout_sticky", 32'(timeout), 32'd1);

      // Asynchronous reset in WAIT, with an ack that must be ignored.
      imem_ack = 1'b1;
      rstn = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;
      drive(0, 0, 0, 0);
      tick();
      chk("post_reset_addr", imem_addr, 32'h0);

      // Randomized traffic.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         ackp = ((cyc / 400) % 2 == 1) ? 14 : 2;
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
               m_out && ($urandom_range(0, ackp) == 0));
         if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
         if (imem_ack) stall = 1'b0;
         if ($urandom_range(0, 599) == 0) begin
            rstn = 1'b0;
            #1;
            model_reset();
            check_all();
            @(posedge clk);
            #1;
            rstn = 1'b1;
         end else begin
            tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
